uart_rx_fifo_wr: RTL
====================

UART_RX_FIFO_WR -- requirements
Module: uart_rx_fifo_wr

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; even; minimum 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 full  input  1  downstream FIFO full flag.
REQ-006 ovf_clr  input  1  one-cycle pulse that clears overflow.
REQ-007 wen  output  1  one-cycle FIFO write strobe.
REQ-008 din  output  8  received byte; valid whenever wen=1.
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 overflow  output  1  sticky flag: a good byte was dropped because full=1.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before use; all rx references below mean the synchronized rx (rxs).
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HI, plus PARITY when RX_PARITY_EN is defined.
REQ-014 IDLE: rxs=0 SHALL move the FSM to START and clear the bit-timer.
REQ-015 START: at timer=CLKS_PER_BIT/2-1 the FSM SHALL sample rxs; 0 goes to DATA, 1 (glitch) returns to IDLE with no output.
REQ-016 DATA: every CLKS_PER_BIT cycles the FSM SHALL sample rxs into a shift register, LSB first; after 8 samples it goes to STOP (or PARITY).
REQ-017 STOP: after CLKS_PER_BIT cycles the FSM SHALL sample rxs.
- rxs=1: byte accepted, go to IDLE.
- rxs=0: pulse frame_err, no write, go to WAIT_HI.
REQ-018 WAIT_HI SHALL stay until rxs=1, then go to IDLE.
REQ-019 On byte acceptance with full=0, the block SHALL drive wen=1 for exactly one cycle, in the cycle after the stop sample, with din=byte.
REQ-020 din SHALL hold its value until the next write.
REQ-021 On byte acceptance with full=1, the block SHALL keep wen=0, discard the byte and set overflow.
REQ-022 overflow SHALL clear on ovf_clr=1; if a set event coincides with ovf_clr, the set wins.
REQ-023 wen SHALL never be asserted in two consecutive cycles.
REQ-024 The bit-timer SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL reset to 0 at each sample point.
REQ-025 The bit-counter SHALL be 4 bits wide.

Reset
REQ-026 With reset_n=0 at a clock edge, the following SHALL take effect on that edge:
- FSM goes to IDLE.
- Synchronizer flops are set to 1.
- wen=0, din=8'h00, frame_err=0, overflow=0, busy=0.
- Timers and the shift register are cleared.
REQ-027 Reset mid-frame SHALL abandon the frame with no wen and no error pulse.

Configuration
REQ-028 Macro RX_PARITY_EN:
- Defined: the frame is 8E1; a PARITY state follows DATA and samples one extra bit after CLKS_PER_BIT cycles.
- Parity mismatch: the byte is discarded, output parity_err (1 bit, one-cycle pulse) fires in the cycle after the stop sample, and overflow is not touched.
- Undefined: no PARITY state and no parity_err port; the frame is 8N1.

Verification
REQ-029 Byte 8'hA5, 8N1, CLKS_PER_BIT=16, full=0 -> single wen pulse, din=8'hA5, frame_err=0.
REQ-030 Two back-to-back frames 8'h01 then 8'hFF -> two wen pulses, separated by at least 160 cycles, din 8'h01 then 8'hFF.
REQ-031 rx low for 4 cycles, then high -> no wen, busy returns to 0, FSM in IDLE.
REQ-032 Frame 8'h3C with stop bit=0 -> frame_err pulse, no wen, busy stays high until rx=1.
REQ-033 full=1 during frame 8'h55 -> wen=0 and overflow=1; then ovf_clr pulse -> overflow=0.
REQ-034 reset_n=0 in the middle of DATA of 8'hC3, then a clean frame 8'h12 -> only one wen, with din=8'h12.
REQ-035 (RX_PARITY_EN) 8'h07 sent with wrong parity -> parity_err pulse, no wen; the same byte with correct parity -> wen, din=8'h07.

Source files
------------

// File: rtl/uart_rx_fifo_wr.sv
// UART receiver (8N1, or 8E1 when RX_PARITY_EN is defined) that writes each good byte
// into a downstream FIFO via a one-cycle wen strobe and flags dropped bytes in a sticky overflow bit.
module uart_rx_fifo_wr #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       full,
    input  logic       ovf_clr,
    output logic       wen,
    output logic [7:0] din,
    output logic       frame_err,
    output logic       overflow,
`ifdef RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_param
            $error("CLKS_PER_BIT must be even and at least 4");
        end
    endgenerate

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

    logic [1:0]    sync_reg;
    logic          rxs;
    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [3:0]    bitcnt_reg, bitcnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          wen_reg, wen_next;
    logic [7:0]    din_reg, din_next;
    logic          ferr_reg, ferr_next;
    logic          ovf_reg, ovf_next;
    logic          accept;
    logic          ovf_set;
`ifdef RX_PARITY_EN
    logic          pbit_reg, pbit_next;
    logic          perr_reg, perr_next;
`endif

    // Synchronizer resets to the idle-high line level so reset never fakes a start bit.
    assign rxs = sync_reg[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_reg   <= 2'b11;
            state_reg  <= IDLE;
            timer_reg  <= '0;
            bitcnt_reg <= '0;
            shift_reg  <= '0;
            wen_reg    <= 1'b0;
            din_reg    <= 8'h00;
            ferr_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
`ifdef RX_PARITY_EN
            pbit_reg   <= 1'b0;
            perr_reg   <= 1'b0;
`endif
        end else begin
            sync_reg   <= {sync_reg[0], rx};
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            bitcnt_reg <= bitcnt_next;
            shift_reg  <= shift_next;
            wen_reg    <= wen_next;
            din_reg    <= din_next;
            ferr_reg   <= ferr_next;
            ovf_reg    <= ovf_next;
`ifdef RX_PARITY_EN
            pbit_reg   <= pbit_next;
            perr_reg   <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg + 1'b1;
        bitcnt_next = bitcnt_reg;
        shift_next  = shift_reg;
        wen_next    = 1'b0;
        din_next    = din_reg;
        ferr_next   = 1'b0;
        ovf_next    = ovf_reg;
        accept      = 1'b0;
        ovf_set     = 1'b0;
`ifdef RX_PARITY_EN
        pbit_next   = pbit_reg;
        perr_next   = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (!rxs) begin
                    state_next = START;
                end
            end
            // Half-bit wait centres every later sample in its bit cell.
            START: begin
                if (timer_reg == HALF_LAST) begin
                    timer_next  = '0;
                    bitcnt_next = '0;
                    state_next  = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next  = '0;
                    shift_next  = {rxs, shift_reg[7:1]};
                    bitcnt_next = bitcnt_reg + 4'd1;
                    if (bitcnt_reg == 4'd7) begin
`ifdef RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    pbit_next  = rxs;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    if (rxs) begin
                        state_next = IDLE;
`ifdef RX_PARITY_EN
                        // Even parity: data plus parity bit must hold an even count of ones.
                        if (^{shift_reg, pbit_reg}) begin
                            perr_next = 1'b1;
                        end else begin
                            accept = 1'b1;
                        end
`else
                        accept = 1'b1;
`endif
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                timer_next = '0;
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase

        if (accept) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                wen_next = 1'b1;
                din_next = shift_reg;
            end
        end

        // A drop in the same cycle as a clear must leave the flag set.
        if (ovf_set) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    assign wen       = wen_reg;
    assign din       = din_reg;
    assign frame_err = ferr_reg;
    assign overflow  = ovf_reg;
    assign busy      = (state_reg != IDLE);
`ifdef RX_PARITY_EN
    assign parity_err = perr_reg;
`endif

endmodule
